layered_pixel_compositor: RTL and testbench

- Pipelined, parametrised successor to the combinational beam painter: merges NUM_LAYERS sprite layers (doodle, platforms, monsters, HUD, ...) into one RGB stream for the VGA output stage.
- Adds a fixed-priority layer mux, registered outputs with a fixed 2-cycle latency, and a frame-counted full-screen "flash" effect (hit or game-over).
- Sits between the per-object sprite renderers and the VGA DAC pins; the VGA timing generator supplies beam_x, beam_y, draw and frame_start.

---
 rtl/layered_pixel_compositor.sv | 200 ++++++++++++++++++++
 tb/tb_layered_pixel_compositor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/layered_pixel_compositor.sv
// Layered pixel compositor: merges NUM_LAYERS sprite layers into one RGB
// stream with a fixed 2-cycle latency and a frame-counted inversion flash.
// Ports: clk, reset (sync, active-high); beam_x, beam_y, draw, frame_start
// from VGA timing; layer_colors / layer_transparencies from sprite renderers;
// flash_trigger starts the flash; red/green/blue, pixel_valid, flash_active.
// Optional macro COMPOSITOR_GRID_BG_EN: graph-paper background every
// GRID_PITCH pixels instead of solid BG_COLOR.
module layered_pixel_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 4,
  parameter int GAME_VIEW_LEFT_BORDER_X = 160,
  parameter int GAME_VIEW_RIGHT_BORDER_X = 480,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = 'hFFF,
  parameter int FLASH_FRAMES = 8,
  parameter int GRID_PITCH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [10:0]                          beam_x,
  input  logic [9:0]                           beam_y,
  input  logic                                 draw,
  input  logic                                 frame_start,
  input  logic [NUM_LAYERS-1:0][2:0][COLOR_W-1:0] layer_colors,
  input  logic [NUM_LAYERS-1:0]                layer_transparencies,
  input  logic                                 flash_trigger,
  output logic [COLOR_W-1:0]                   red,
  output logic [COLOR_W-1:0]                   green,
  output logic [COLOR_W-1:0]                   blue,
  output logic                                 pixel_valid,
  output logic                                 flash_active
);

  localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
  localparam logic [10:0] LEFT_X = 11'(GAME_VIEW_LEFT_BORDER_X);
  localparam logic [10:0] RIGHT_X = 11'(GAME_VIEW_RIGHT_BORDER_X);

  typedef logic [2:0][COLOR_W-1:0] rgb_t;
  typedef enum logic [0:0] {IDLE, FLASH} state_t;

  localparam rgb_t BG = '{BG_COLOR[COLOR_W-1:0],
                          BG_COLOR[2*COLOR_W-1 -: COLOR_W],
                          BG_COLOR[3*COLOR_W-1 -: COLOR_W]};

  // Only beam_y low bits feed the grid; the rest is intentionally unused.
  logic w_unused;
  assign w_unused = &{1'b0, beam_y, 1'(GRID_PITCH)};

  // Flash FSM
  state_t     r_state, w_state_nxt;
  logic [7:0] r_count, w_count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // A trigger always wins over a coincident frame_start.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        if (flash_trigger) begin
          w_state_nxt = FLASH;
          w_count_nxt = FLASH_LOAD;
        end
      end
      FLASH: begin
        if (flash_trigger) begin
          w_count_nxt = FLASH_LOAD;
        end else if (frame_start) begin
          if (r_count == 8'd1) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count - 8'd1;
          end
        end
      end
    endcase
  end

  assign flash_active = (r_state == FLASH);

  // Stage 1: priority select; only the winning layer's colour is muxed so
  // garbage on transparent layers never reaches the registers.
  logic             w_hit;
  logic [SEL_W-1:0] w_sel;
  rgb_t             w_col;
  logic             w_border;

  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (!layer_transparencies[i]) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
    w_col = w_hit ? layer_colors[w_sel] : '0;
  end

  assign w_border = (beam_x <= LEFT_X) || (beam_x >= RIGHT_X);

  logic r_s1_draw;
  logic r_s1_border;
  logic r_s1_hit;
  rgb_t r_s1_col;

`ifdef COMPOSITOR_GRID_BG_EN
  localparam int GRID_LOG = (GRID_PITCH > 1) ? $clog2(GRID_PITCH) : 1;

  // Scale a 4-bit nibble to COLOR_W by keeping its top bits.
  function automatic logic [COLOR_W-1:0] scale4(input logic [3:0] v);
    logic [COLOR_W-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      j = i + 4 - COLOR_W;
      if (j >= 0 && j < 4) r[i] = v[j];
    end
    return r;
  endfunction

  localparam rgb_t GRID = '{scale4(4'hF), scale4(4'hD), scale4(4'hC)};

  logic w_grid;
  logic r_s1_grid;
  assign w_grid = (beam_x[GRID_LOG-1:0] == '0) ||
                  (beam_y[GRID_LOG-1:0] == '0);

  always_ff @(posedge clk) begin
    if (reset) r_s1_grid <= 1'b0;
    else       r_s1_grid <= w_grid;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_draw   <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_col    <= '0;
    end else begin
      r_s1_draw   <= draw;
      r_s1_border <= w_border;
      r_s1_hit    <= w_hit;
      r_s1_col    <= w_col;
    end
  end

  // Stage 2: blank/border, background, flash inversion.
  rgb_t w_bg;
  rgb_t w_pix;

  always_comb begin
`ifdef COMPOSITOR_GRID_BG_EN
    w_bg = r_s1_grid ? GRID : BG;
`else
    w_bg = BG;
`endif
    w_pix = '0;
    if (r_s1_draw && !r_s1_border) begin
      w_pix = r_s1_hit ? r_s1_col : w_bg;
      if (r_state == FLASH) begin
        for (int c = 0; c < 3; c++) w_pix[c] = ~w_pix[c];
      end
    end
  end

  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_red   <= w_pix[0];
      r_green <= w_pix[1];
      r_blue  <= w_pix[2];
      r_valid <= r_s1_draw;
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign pixel_valid = r_valid;

endmodule

// File: tb/tb_layered_pixel_compositor.sv
// Scoreboard bench for layered_pixel_compositor (FLASH_FRAMES = 2).
// Stimulus pushes expected {valid,R,G,B}; a monitor pops two clocks later.
module tb_layered_pixel_compositor;

  logic                  clk;
  logic                  reset;
  logic [10:0]           beam_x;
  logic [9:0]            beam_y;
  logic                  draw;
  logic                  frame_start;
  logic [3:0][2:0][3:0]  layer_colors;
  logic [3:0]            layer_transparencies;
  logic                  flash_trigger;
  logic [3:0]            red, green, blue;
  logic                  pixel_valid;
  logic                  flash_active;

  layered_pixel_compositor #(
    .FLASH_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .beam_x(beam_x),
    .beam_y(beam_y),
    .draw(draw),
    .frame_start(frame_start),
    .layer_colors(layer_colors),
    .layer_transparencies(layer_transparencies),
    .flash_trigger(flash_trigger),
    .red(red),
    .green(green),
    .blue(blue),
    .pixel_valid(pixel_valid),
    .flash_active(flash_active)
  );

  typedef struct {
    string       nm;
    logic [12:0] e;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic issue = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: test did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0][3:0] mk(input logic [11:0] v);
    logic [2:0][3:0] c;
    c[0] = v[11:8];
    c[1] = v[7:4];
    c[2] = v[3:0];
    return c;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One stimulus cycle, driven just after a falling edge.
  task automatic cyc(input string nm, input logic [10:0] x,
                     input logic [9:0] y, input logic d,
                     input logic [3:0] tr, input logic trig,
                     input logic fs, input logic sb,
                     input logic ev, input logic [11:0] erg);
    exp_t t;
    beam_x = x;
    beam_y = y;
    draw = d;
    layer_transparencies = tr;
    flash_trigger = trig;
    frame_start = fs;
    issue = sb;
    if (sb) begin
      t.nm = nm;
      t.e = {ev, erg};
      q.push_back(t);
    end
    @(negedge clk);
    issue = 1'b0;
    flash_trigger = 1'b0;
    frame_start = 1'b0;
  endtask

  // Monitor: output after edge N belongs to the input sampled at edge N-1.
  initial begin : monitor
    logic cur;
    logic d1;
    exp_t t;
    d1 = 1'b0;
    forever begin
      @(posedge clk);
      cur = issue;
      #1;
      if (d1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_underflow: no expected entry");
        end else begin
          t = q.pop_front();
          chk(t.nm, {3'b0, pixel_valid, red, green, blue}, {3'b0, t.e});
        end
      end
      d1 = cur;
    end
  end

  initial begin
    reset = 1'b1;
    beam_x = '0;
    beam_y = '0;
    draw = 1'b0;
    frame_start = 1'b0;
    flash_trigger = 1'b0;
    layer_transparencies = 4'hF;
    layer_colors = '0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {4'h0, red, green, blue}, 16'h0);
    chk("rst_valid", {15'h0, pixel_valid}, 16'h0);
    chk("rst_flash", {15'h0, flash_active}, 16'h0);
    reset = 1'b0;

    // Priority
    layer_colors[0] = 'x;
    layer_colors[1] = mk(12'hF00);
    layer_colors[2] = mk(12'h0F0);
    layer_colors[3] = mk(12'h00F);
    cyc("prio_l1", 300, 50, 1, 4'b0001, 0, 0, 1, 1, 12'hF00);
    cyc("prio_l2", 300, 50, 1, 4'b0011, 0, 0, 1, 1, 12'h0F0);
    cyc("prio_l3", 300, 50, 1, 4'b0111, 0, 0, 1, 1, 12'h00F);
    layer_colors[0] = mk(12'hABC);
    cyc("prio_l0", 300, 50, 1, 4'b0000, 0, 0, 1, 1, 12'hABC);

    // Borders
    cyc("brd_160", 160, 50, 1, 4'hF, 0, 0, 1, 1, 12'h000);
    cyc("brd_480", 480, 50, 1, 4'hF, 0, 0, 1, 1, 12'h000);
    cyc("brd_161", 161, 50, 1, 4'hF, 0, 0, 1, 1, 12'hFFF);
    cyc("brd_479", 479, 50, 1, 4'hF, 0, 0, 1, 1, 12'hFFF);
    cyc("brd_0", 0, 50, 1, 4'hF, 0, 0, 1, 1, 12'h000);
    cyc("brd_2047", 2047, 50, 1, 4'hF, 0, 0, 1, 1, 12'h000);

    // Blanking
    layer_colors[0] = mk(12'h123);
    cyc("blank", 300, 50, 0, 4'b1110, 0, 0, 1, 0, 12'h000);

    // Flash on and expiry
    cyc("idle_px", 300, 50, 1, 4'b1110, 0, 0, 1, 1, 12'h123);
    chk("fl_pre", {15'h0, flash_active}, 16'h0);
    cyc("fl_on", 300, 50, 1, 4'b1110, 1, 0, 1, 1, 12'hEDC);
    chk("fl_rise", {15'h0, flash_active}, 16'h1);
    cyc("fl_px", 300, 50, 1, 4'b1110, 0, 0, 1, 1, 12'hEDC);
    cyc("fl_fs1", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'hEDC);
    chk("fl_after1", {15'h0, flash_active}, 16'h1);
    cyc("fl_fs2", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'h123);
    chk("fl_after2", {15'h0, flash_active}, 16'h0);
    cyc("fl_off", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'h123);
    chk("fl_idle_fs", {15'h0, flash_active}, 16'h0);
    cyc("fl_brd", 100, 50, 1, 4'b1110, 1, 0, 1, 1, 12'h000);

    // Retrigger collides with frame_start at count 1
    cyc("rt_fs1", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'hEDC);
    cyc("rt_col", 300, 50, 1, 4'b1110, 1, 1, 1, 1, 12'hEDC);
    chk("rt_active", {15'h0, flash_active}, 16'h1);
    cyc("rt_fs2", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'hEDC);
    chk("rt_reload", {15'h0, flash_active}, 16'h1);
    cyc("rt_fs3", 300, 50, 1, 4'b1110, 0, 1, 1, 1, 12'h123);
    chk("rt_end", {15'h0, flash_active}, 16'h0);
    cyc("rt_tail", 300, 50, 1, 4'b1110, 0, 0, 1, 1, 12'h123);

    // Reset mid-flash
    cyc("rs_trig", 300, 50, 1, 4'b1110, 1, 0, 0, 1, 12'h000);
    cyc("rs_fill", 300, 50, 1, 4'b1110, 0, 0, 0, 1, 12'h000);
    cyc("rs_fill2", 300, 50, 1, 4'b1110, 0, 0, 0, 1, 12'h000);
    chk("rs_pre", {15'h0, flash_active}, 16'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_flash", {15'h0, flash_active}, 16'h0);
    chk("rs_rgb", {4'h0, red, green, blue}, 16'h0);
    chk("rs_valid", {15'h0, pixel_valid}, 16'h0);
    reset = 1'b0;
    cyc("rs_post", 300, 50, 1, 4'b1110, 0, 0, 1, 1, 12'h123);

`ifdef COMPOSITOR_GRID_BG_EN
    cyc("grid_320", 320, 33, 1, 4'hF, 0, 0, 1, 1, 12'hCDF);
    cyc("grid_321", 321, 33, 1, 4'hF, 0, 0, 1, 1, 12'hFFF);
    cyc("grid_y32", 321, 32, 1, 4'hF, 0, 0, 1, 1, 12'hCDF);
`endif

    draw = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 16'(q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
